ofifo: RTL and testbench
========================

Name: ofifo

Overview:
- Output FIFO directly downstream of the MAC array inside the corelet.
- Accepts per-column partial sums, which arrive skewed in time across columns because of systolic flow.
- Re-aligns them into whole rows: presents a complete col-wide row only once every column holds data.
- The SFP/psum path pops one aligned row per read.

Parameters:
- col, 8, number of MAC columns (independent column lanes).
- psum_bw, 16, width of one partial sum.
- depth, 64, entries per column lane; power of two, >= 2.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in  input  psum_bw*col  column c data on bits [psum_bw*(c+1)-1 : psum_bw*c].
- wr  input  col  per-column write strobe, one bit per lane.
- rd  input  1  pop one aligned row.
- out  output  psum_bw*col  head row, first-word-fall-through.
- o_full  output  1  any lane full.
- o_ready  output  1  no lane full; equals !o_full.
- o_valid  output  1  every lane non-empty.

Behaviour:
- Lanes: each lane is a circular buffer with wr_ptr and rd_ptr of width log2(depth)+1.
  - empty: wr_ptr == rd_ptr.
  - full: MSBs differ and the low bits are equal.
  - Pointers wrap naturally modulo 2*depth.
- Reset (asynchronous assert, release synchronous to clk): all pointers 0. Outputs: o_valid=0, o_full=0, o_ready=1, out=0. Memory contents are not reset.
- Reset mid-operation: all stored data discarded immediately; the state afterwards is identical to a power-on reset.
- Write: at a posedge with wr[c]=1 and lane c not full, in-slice c is stored at wr_ptr[c] and wr_ptr[c] increments.
  - Write to a full lane with no concurrent pop: data dropped, pointer unchanged.
- Read: at a posedge with rd=1 and o_valid=1, every lane's rd_ptr increments together.
  - rd with o_valid=0: ignored, no pointer moves.
- Simultaneous read and write on the same lane in the same cycle:
  - Both take effect; occupancy unchanged.
  - A full lane accepts the write in that cycle because the pop frees a slot; the full test uses the pre-edge pointers plus the pop.
  - An empty lane cannot be popped (o_valid=0), so its write proceeds alone.
- out: combinational from the head of each lane (mem[rd_ptr]) when o_valid=1; forced to all zeros when o_valid=0.
- Flag latency:
  - A write at edge n makes its lane non-empty immediately after edge n.
  - o_valid rises after the edge that fills the last empty lane.
  - o_full and o_valid are combinational from the pointers; no extra pipeline delay.
- Ordering: strict FIFO per lane. Row k of out consists of the k-th accepted word of each lane.
- Arithmetic: none on data; data passes through bit-exact.

Optional Feature:
- Macro: OFIFO_OVERFLOW_EN.
- Defined: adds output port o_overflow (1 bit).
  - Sets on any posedge where a lane drops a write (wr[c]=1, lane full, no concurrent pop).
  - Sticky until reset; reset value 0.
- Not defined: port absent; drops are silent. All other behaviour is identical.

Decomposition:
- Shared package holds:
  - default widths (PSUM_BW=16, COL=8, OFIFO_DEPTH=64);
  - OFIFO_PTR_W = $clog2(OFIFO_DEPTH)+1;
  - a typedef for one psum word.
- One sub-module, ofifo_lane: single-column circular buffer.
  - Inputs: wr, data, pop (driven by the top).
  - Outputs: head data, empty, full, and a drop pulse.
  - The top instantiates col lanes, ANDs the !empty flags into o_valid, ORs the full flags into o_full, and drives the shared pop = rd & o_valid.

Test Plan:
- Reset, then idle → o_valid=0, o_full=0, o_ready=1, out=0. Pulse rd → no change.
- Skew: write lane c at cycle c (c=0..7) with value 16'h0100+c, one lane per cycle.
  - o_valid stays 0 until the edge at cycle 7, then rises.
  - out = {16'h0107,...,16'h0100}.
  - rd one cycle → o_valid=0.
- Fill: 64 full-row writes with row index i in every lane → o_full=1 after the 64th edge.
  - A 65th write is dropped (o_overflow=1 with OFIFO_OVERFLOW_EN).
  - 64 reads return rows 0..63 in order, then o_valid=0.
- Full plus simultaneous rd and wr=all ones → pop and push both succeed; o_full stays 1. The new row appears as the 64th row after the pops.
- Wrap-around: 200 cycles of random per-lane writes and reads with occupancy kept below 64 → every popped row matches a per-lane scoreboard; pointers wrap with no loss.
- Assert reset mid-stream with 10 rows buffered → o_valid drops to 0 at once. After release, the first written row is read back, not the stale data.

Source files
------------

// File: rtl/ofifo_pkg.sv
// Shared widths and types for the output FIFO that re-aligns skewed MAC
// column partial sums into whole rows.
package ofifo_pkg;
  localparam int PSUM_BW     = 16;
  localparam int COL         = 8;
  localparam int OFIFO_DEPTH = 64;
  localparam int OFIFO_PTR_W = $clog2(OFIFO_DEPTH) + 1;

  typedef logic [PSUM_BW-1:0] psum_t;
endpackage

// File: rtl/ofifo_lane.sv
// One column lane: circular buffer with extra-MSB pointers so that full
// and empty are distinguishable without a counter.
module ofifo_lane
  import ofifo_pkg::*;
#(
  parameter int DW    = PSUM_BW,
  parameter int DEPTH = OFIFO_DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr,
  input  logic [DW-1:0] data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic          empty,
  output logic          full,
  output logic          drop
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic          push;
  logic          pop_ok;

  always_comb begin
    empty  = (wr_ptr_q == rd_ptr_q);
    full   = (wr_ptr_q[AW] != rd_ptr_q[AW])
          && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop_ok = pop && !empty;
    // a concurrent pop frees the slot a full lane would otherwise refuse
    push   = wr && (!full || pop_ok);
    drop   = wr && full && !pop_ok;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push)   wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok) rd_ptr_d = rd_ptr_q + PW'(1);
    head = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= data;
  end
endmodule

// File: rtl/ofifo.sv
// Output FIFO: col independent lanes, row presented once every lane has data.
// Define OFIFO_OVERFLOW_EN to add the sticky o_overflow port.
module ofifo
  import ofifo_pkg::*;
#(
  parameter int col     = COL,
  parameter int psum_bw = PSUM_BW,
  parameter int depth   = OFIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [psum_bw*col-1:0] in,
  input  logic [col-1:0]         wr,
  input  logic                   rd,
  output logic [psum_bw*col-1:0] out,
  output logic                   o_full,
  output logic                   o_ready,
  output logic                   o_valid
`ifdef OFIFO_OVERFLOW_EN
  ,
  output logic                   o_overflow
`endif
);
  logic [col-1:0]     empty_w;
  logic [col-1:0]     full_w;
  logic [col-1:0]     drop_w;
  logic [psum_bw-1:0] head_w [col];
  logic               pop;

  for (genvar c = 0; c < col; c++) begin : g_lane
    ofifo_lane #(
      .DW    (psum_bw),
      .DEPTH (depth)
    ) u_lane (
      .clk   (clk),
      .reset (reset),
      .wr    (wr[c]),
      .data  (in[psum_bw*c +: psum_bw]),
      .pop   (pop),
      .head  (head_w[c]),
      .empty (empty_w[c]),
      .full  (full_w[c]),
      .drop  (drop_w[c])
    );
  end

  always_comb begin
    o_valid = &(~empty_w);
    o_full  = |full_w;
    o_ready = !o_full;
    pop     = rd && o_valid;
    out     = '0;
    if (o_valid) begin
      for (int c = 0; c < col; c++) begin
        out[psum_bw*c +: psum_bw] = head_w[c];
      end
    end
  end

`ifdef OFIFO_OVERFLOW_EN
  logic overflow_q, overflow_d;

  always_comb begin
    overflow_d = overflow_q || (|drop_w);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) overflow_q <= 1'b0;
    else       overflow_q <= overflow_d;
  end

  assign o_overflow = overflow_q;
`else
  logic unused_drop;
  assign unused_drop = |drop_w;
`endif
endmodule

// File: tb/tb_ofifo.sv
// Directed bench for ofifo: reset, skew alignment, fill/drop, full r+w,
// randomized wrap against per-lane queues, and mid-stream reset.
module tb_ofifo;
  import ofifo_pkg::*;

  localparam int W = PSUM_BW * COL;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] in;
  logic [COL-1:0] wr;
  logic         rd;
  logic [W-1:0] out;
  logic         o_full, o_ready, o_valid;
`ifdef OFIFO_OVERFLOW_EN
  logic         o_overflow;
`endif

  int checks = 0;
  int failures = 0;

  psum_t q [COL][$];

  ofifo dut (
    .clk     (clk),
    .reset   (reset),
    .in      (in),
    .wr      (wr),
    .rd      (rd),
    .out     (out),
    .o_full  (o_full),
    .o_ready (o_ready),
    .o_valid (o_valid)
`ifdef OFIFO_OVERFLOW_EN
    ,
    .o_overflow (o_overflow)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] row(int i);
    logic [W-1:0] r;
    r = '0;
    for (int c = 0; c < COL; c++) begin
      r[PSUM_BW*c +: PSUM_BW] = PSUM_BW'((c << 8) | (i & 8'hff));
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in = '0; wr = '0; rd = 1'b0;
    step(); step();
    reset = 1'b0;
    step();
    checks++;
    if (o_valid !== 1'b0 || o_full !== 1'b0 || o_ready !== 1'b1
        || out !== '0) begin
      failures++;
      $display("FAIL reset_idle v=%b f=%b r=%b out=%h exp v=0 f=0 r=1 out=0",
               o_valid, o_full, o_ready, out);
    end
`ifdef OFIFO_OVERFLOW_EN
    checks++;
    if (o_overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_ovf got=%b exp=0", o_overflow);
    end
`endif
    rd = 1'b1;
    step();
    rd = 1'b0;
    checks++;
    if (o_valid !== 1'b0 || o_full !== 1'b0 || out !== '0) begin
      failures++;
      $display("FAIL rd_empty v=%b f=%b out=%h exp v=0 f=0 out=0",
               o_valid, o_full, out);
    end
  endtask

  task automatic test_skew();
    logic [W-1:0] exp;
    exp = '0;
    for (int c = 0; c < COL; c++) begin
      wr = '0;
      wr[c] = 1'b1;
      in = '0;
      in[PSUM_BW*c +: PSUM_BW] = PSUM_BW'(16'h0100 + c);
      exp[PSUM_BW*c +: PSUM_BW] = PSUM_BW'(16'h0100 + c);
      step();
      checks++;
      if (o_valid !== (c == COL - 1)) begin
        failures++;
        $display("FAIL skew_valid lane=%0d got=%b exp=%b",
                 c, o_valid, (c == COL - 1));
      end
    end
    wr = '0;
    checks++;
    if (out !== exp) begin
      failures++;
      $display("FAIL skew_out got=%h exp=%h", out, exp);
    end
    rd = 1'b1;
    step();
    rd = 1'b0;
    checks++;
    if (o_valid !== 1'b0 || out !== '0) begin
      failures++;
      $display("FAIL skew_pop v=%b out=%h exp v=0 out=0", o_valid, out);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < OFIFO_DEPTH; i++) begin
      wr = '1;
      in = row(i);
      step();
      checks++;
      if (o_full !== (i == OFIFO_DEPTH - 1) || o_ready !== !o_full) begin
        failures++;
        $display("FAIL fill_full i=%0d full=%b ready=%b exp full=%b",
                 i, o_full, o_ready, (i == OFIFO_DEPTH - 1));
      end
    end
`ifdef OFIFO_OVERFLOW_EN
    checks++;
    if (o_overflow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_pre got=%b exp=0", o_overflow);
    end
`endif
    in = row(8'hee);
    step();
    wr = '0;
    checks++;
    if (o_full !== 1'b1) begin
      failures++;
      $display("FAIL drop_full got=%b exp=1", o_full);
    end
`ifdef OFIFO_OVERFLOW_EN
    checks++;
    if (o_overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_set got=%b exp=1", o_overflow);
    end
`endif
    for (int i = 0; i < OFIFO_DEPTH; i++) begin
      checks++;
      if (out !== row(i)) begin
        failures++;
        $display("FAIL fill_read i=%0d got=%h exp=%h", i, out, row(i));
      end
      rd = 1'b1;
      step();
    end
    rd = 1'b0;
    checks++;
    if (o_valid !== 1'b0 || o_full !== 1'b0) begin
      failures++;
      $display("FAIL fill_drain v=%b f=%b exp v=0 f=0", o_valid, o_full);
    end
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < OFIFO_DEPTH; i++) begin
      wr = '1;
      in = row(i);
      step();
    end
    rd = 1'b1;
    in = row(100);
    step();
    rd = 1'b0;
    wr = '0;
    checks++;
    if (o_full !== 1'b1) begin
      failures++;
      $display("FAIL full_rw_full got=%b exp=1", o_full);
    end
    for (int i = 1; i <= OFIFO_DEPTH; i++) begin
      logic [W-1:0] exp;
      exp = (i == OFIFO_DEPTH) ? row(100) : row(i);
      checks++;
      if (out !== exp) begin
        failures++;
        $display("FAIL full_rw_read k=%0d got=%h exp=%h", i, out, exp);
      end
      rd = 1'b1;
      step();
    end
    rd = 1'b0;
    checks++;
    if (o_valid !== 1'b0) begin
      failures++;
      $display("FAIL full_rw_drain got=%b exp=0", o_valid);
    end
  endtask

  task automatic test_wrap();
    for (int cyc = 0; cyc < 200; cyc++) begin
      logic mvalid;
      logic [W-1:0] exp;
      mvalid = 1'b1;
      exp = '0;
      for (int c = 0; c < COL; c++) begin
        if (q[c].size() == 0) mvalid = 1'b0;
      end
      if (mvalid) begin
        for (int c = 0; c < COL; c++) exp[PSUM_BW*c +: PSUM_BW] = q[c][0];
      end
      checks++;
      if (o_valid !== mvalid || out !== exp) begin
        failures++;
        $display("FAIL wrap cyc=%0d v=%b out=%h exp v=%b out=%h",
                 cyc, o_valid, out, mvalid, exp);
      end
      rd = mvalid && ($urandom_range(0, 1) == 1);
      for (int c = 0; c < COL; c++) begin
        wr[c] = (q[c].size() < OFIFO_DEPTH - 1)
             && ($urandom_range(0, 1) == 1);
        in[PSUM_BW*c +: PSUM_BW] = PSUM_BW'($urandom);
      end
      step();
      for (int c = 0; c < COL; c++) begin
        if (rd) void'(q[c].pop_front());
        if (wr[c]) q[c].push_back(in[PSUM_BW*c +: PSUM_BW]);
      end
    end
    rd = 1'b0;
    wr = '0;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 10; i++) begin
      wr = '1;
      in = row(40 + i);
      step();
    end
    wr = '0;
    checks++;
    if (o_valid !== 1'b1) begin
      failures++;
      $display("FAIL mid_pre got=%b exp=1", o_valid);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (o_valid !== 1'b0 || out !== '0 || o_full !== 1'b0) begin
      failures++;
      $display("FAIL mid_async v=%b f=%b out=%h exp v=0 f=0 out=0",
               o_valid, o_full, out);
    end
    step();
    reset = 1'b0;
    for (int c = 0; c < COL; c++) q[c].delete();
`ifdef OFIFO_OVERFLOW_EN
    checks++;
    if (o_overflow !== 1'b0) begin
      failures++;
      $display("FAIL mid_ovf got=%b exp=0", o_overflow);
    end
`endif
    wr = '1;
    in = row(55);
    step();
    wr = '0;
    checks++;
    if (o_valid !== 1'b1 || out !== row(55)) begin
      failures++;
      $display("FAIL mid_first v=%b out=%h exp v=1 out=%h",
               o_valid, out, row(55));
    end
    rd = 1'b1;
    step();
    rd = 1'b0;
    checks++;
    if (o_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_pop got=%b exp=0", o_valid);
    end
  endtask

  initial begin
    test_reset();
    test_skew();
    test_fill();
    test_full_rw();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
